// File: rtl/sram_access_arbiter.sv
// Two-port round-robin arbiter and access sequencer for an asynchronous work
// SRAM. Each granted access runs SETUP -> STROBE (STROBE_CYCLES) -> HOLD, with
// all SRAM-side signals and acknowledges driven straight from registers.
module sram_access_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 11,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic [ADDR_WIDTH-1:0] sram_address,
    output logic [DATA_WIDTH-1:0] sram_data_in,
    input  logic [DATA_WIDTH-1:0] sram_data_out,
    output logic                  sram_write_enable,
    output logic                  sram_output_enable,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q;
    logic       last_grant_b_q;  // 1: port B was granted last
    logic       gnt_b_q;         // port owning the access in flight
    logic       gnt_we_q;
    logic       grant_b;
    logic       any_req;

    // Round-robin pick: a lone requester wins, a tie goes to the port not granted last.
    assign any_req = a_req | b_req;
    assign grant_b = b_req & (~a_req | ~last_grant_b_q);
    assign busy    = (state_q != IDLE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            state_q <= state_d;
        end
    end

    // Next-state sequencing through the access phases.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_d
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = SETUP;
            SETUP:   state_d = STROBE;
            STROBE:  if (cnt_q == 4'd0) state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered datapath: grant latch, SRAM drive, strobes, read capture and acks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: every output-facing register is reset, including the rdata
            // holding registers, so a reset mid-access leaves no stale strobe or ack.
            cnt_q              <= 4'd0;
            last_grant_b_q     <= 1'b1;
            gnt_b_q            <= 1'b0;
            gnt_we_q           <= 1'b0;
            sram_address       <= '0;
            sram_data_in       <= '0;
            sram_write_enable  <= 1'b1;
            sram_output_enable <= 1'b1;
            a_ack              <= 1'b0;
            b_ack              <= 1'b0;
            a_rdata            <= '0;
            b_rdata            <= '0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        gnt_b_q      <= grant_b;
                        gnt_we_q     <= grant_b ? b_we : a_we;
                        sram_address <= grant_b ? b_addr : a_addr;
                        sram_data_in <= grant_b ? b_wdata : a_wdata;
                    end
                end
                SETUP: begin
                    cnt_q              <= CNT_LOAD;
                    sram_write_enable  <= ~gnt_we_q;
                    sram_output_enable <= gnt_we_q;
                end
                STROBE: begin
                    if (cnt_q == 4'd0) begin
                        sram_write_enable  <= 1'b1;
                        sram_output_enable <= 1'b1;
                        if (!gnt_we_q) begin
                            if (gnt_b_q) b_rdata <= sram_data_out;
                            else         a_rdata <= sram_data_out;
                        end
                        if (gnt_b_q) b_ack <= 1'b1;
                        else         a_ack <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                HOLD: begin
                    last_grant_b_q <= gnt_b_q;
                end
                default: ;
            endcase
        end
    end

endmodule
